// File: rtl/irq_event_unit.sv
// Interrupt event unit: edge-captured and software-set pending bits, masked onto level irq lines.
// Optional `IRQ_EVENT_SYNC_EN adds a 2-flop synchronizer in front of the edge detector.
module irq_event_unit #(
  parameter int unsigned NUM_IRQ = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] event_i,
  output logic [31:0] irq_o,
  output logic        irq_any_o,
  input  logic        save_cause_i,
  input  logic [5:0]  cause_i,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        reg_ack_o,
  output logic [31:0] reg_rdata_o
);

  // Lines at or above NUM_IRQ are tied off everywhere state is written.
  localparam logic [31:0] ImplMask = 32'hFFFF_FFFF >> (32 - NUM_IRQ);

  localparam logic [2:0] AddrMask    = 3'd0;
  localparam logic [2:0] AddrPending = 3'd1;
  localparam logic [2:0] AddrSet     = 3'd2;
  localparam logic [2:0] AddrLost    = 3'd3;
  localparam logic [2:0] AddrId      = 3'd4;

  logic [31:0] mask_q,    mask_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] lost_q,    lost_d;
  logic [31:0] prev_q;
  logic        ack_q;
  logic [31:0] rdata_q,   rdata_d;

  logic [31:0] evt_s;
  logic [31:0] rise;
  logic [31:0] set_bits, clr_bits, core_clr;
  logic        wr_en, rd_en;
  logic        mask_wr, pend_wr, set_wr, lost_wr;
  logic [4:0]  id_idx;
  logic        unused_addr;

  assign unused_addr = ^reg_addr_i[1:0];

`ifdef IRQ_EVENT_SYNC_EN
  logic [31:0] s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= event_i & ImplMask;
      s2_q <= s1_q;
    end
  end

  assign evt_s = s2_q;
`else
  assign evt_s = event_i & ImplMask;
`endif

  assign rise = evt_s & ~prev_q;

  assign wr_en   = reg_req_i & reg_we_i;
  assign rd_en   = reg_req_i & ~reg_we_i;
  assign mask_wr = wr_en & (reg_addr_i[4:2] == AddrMask);
  assign pend_wr = wr_en & (reg_addr_i[4:2] == AddrPending);
  assign set_wr  = wr_en & (reg_addr_i[4:2] == AddrSet);
  assign lost_wr = wr_en & (reg_addr_i[4:2] == AddrLost);

  // Exceptions (cause_i[5]=0) never touch pending state.
  assign core_clr = (save_cause_i && cause_i[5]) ? (32'd1 << cause_i[4:0]) : 32'd0;

  assign set_bits = rise | (set_wr ? reg_wdata_i : 32'd0);
  assign clr_bits = core_clr | (pend_wr ? reg_wdata_i : 32'd0);

  always_comb begin
    // Set dominates clear so an event coinciding with its own ack is not dropped.
    pending_d = (set_bits | (pending_q & ~clr_bits)) & ImplMask;
    lost_d    = ((rise & pending_q & ~clr_bits) |
                 (lost_q & ~(lost_wr ? reg_wdata_i : 32'd0))) & ImplMask;
    mask_d    = mask_wr ? (reg_wdata_i & ImplMask) : mask_q;
  end

  assign irq_o     = pending_q & mask_q;
  assign irq_any_o = |irq_o;

  always_comb begin
    id_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (irq_o[i]) id_idx = 5'(i);
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    if (rd_en) begin
      case (reg_addr_i[4:2])
        AddrMask:    rdata_d = mask_q;
        AddrPending: rdata_d = pending_q;
        AddrSet:     rdata_d = 32'd0;
        AddrLost:    rdata_d = lost_q;
        AddrId:      rdata_d = {irq_any_o, 26'd0, id_idx};
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q    <= '0;
      pending_q <= '0;
      lost_q    <= '0;
      prev_q    <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      mask_q    <= mask_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      prev_q    <= evt_s;
      ack_q     <= reg_req_i;
      rdata_q   <= rdata_d;
    end
  end

  assign reg_ack_o   = ack_q;
  assign reg_rdata_o = rdata_q;

endmodule
